// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder: default geometry,
// latency counter width and the responder FSM state encoding.
package mips_mem_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned DEPTH_LOG2_DEF = 8;
  localparam int unsigned LATENCY_DEF    = 2;

  // LATENCY tops out at 15, so LATENCY-1 always fits in four bits.
  localparam int unsigned LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage : mips_mem_pkg

// File: rtl/mips_dmem_array.sv
// Synchronous single-port RAM, DEPTH words of DATA_W bits, with per-byte write
// enables; read data is registered and held until the next enabled read.
module mips_dmem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [DEPTH_LOG2-1:0]   addr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic [DATA_W/8-1:0]     be_i,
  output logic [DATA_W-1:0]       rdata_o
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned BYTES_N = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately left unreset so a reset mid-transaction keeps
  // whatever write has already landed.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned b = 0; b < BYTES_N; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule : mips_dmem_array

// File: rtl/mips_dmem_resp.sv
// Single-outstanding data-memory responder with fixed LATENCY response timing.
// Define MIPS_DMEM_ERR_CHECK_EN to reject misaligned or out-of-range addresses.
module mips_dmem_resp
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned LATENCY    = LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam logic [LAT_CNT_W-1:0] CNT_LAST = LAT_CNT_W'(LATENCY - 1);

  dmem_state_e            state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
  logic                   ready_en_q;

  logic                   accept;
  logic                   addr_err;
  logic                   mem_en;
  logic [DEPTH_LOG2-1:0]  word_addr;
  logic [DATA_W-1:0]      mem_rdata;

  assign word_addr = req_addr[DEPTH_LOG2+1:2];

`ifdef MIPS_DMEM_ERR_CHECK_EN
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:DEPTH_LOG2+2] != '0);
`else
  // Byte offset and upper bits are dropped: the word index wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
  assign addr_err         = 1'b0;
`endif

  // ready_en_q holds req_ready low until the first edge after reset release.
  assign req_ready = (state_q == IDLE) && ready_en_q;
  assign accept    = req_valid && req_ready;
  assign mem_en    = accept && !addr_err;

  mips_dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (req_we),
    .addr_i  (word_addr),
    .wdata_i (req_wdata),
    .be_i    (req_be),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = '0;
          we_d    = req_we;
          err_d   = addr_err;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The RAM output register only moves on an accepted read, so it stays
  // stable for the whole RESP phase without a separate response register.
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? mem_rdata : '0;

endmodule : mips_dmem_resp

// File: tb/tb_mips_dmem_resp.sv
// Directed self-checking bench for mips_dmem_resp (LATENCY=2, DEPTH_LOG2=8).
module tb_mips_dmem_resp;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mips_dmem_resp #(
    .DATA_W     (32),
    .DEPTH_LOG2 (8),
    .LATENCY    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with rsp_ready held 1; checks latency and payload.
  task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input logic exp_err);
    int unsigned waited;
    int unsigned lat;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    waited    = 0;
    while (!req_ready && waited < 20) begin
      step();
      waited++;
    end
    check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'd2);
    check({tag, ".rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    check({tag, ".err"}, 64'(rsp_err), 64'(exp_err));
    step();
    check({tag, ".done"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;

    step();
    step();
    check("rst.req_ready", 64'(req_ready), 64'd0);
    check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst.rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst.rsp_err",   64'(rsp_err),   64'd0);

    reset = 1'b1;
    #1;
    check("rel.ready_before_edge", 64'(req_ready), 64'd0);
    step();
    check("rel.ready_first_edge", 64'(req_ready), 64'd1);

    // Write then read back
    transact("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    transact("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Byte-enable merge: bytes 0 and 2 take the new value
    transact("wr20a", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
    transact("wr20b", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    transact("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

    // Backpressure, with a second request held during WAIT/RESP
    transact("wr30", 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h30;
    check("bp.ready_idle", 64'(req_ready), 64'd1);
    step();
    req_addr = 32'h10;
    check("bp.accepted", 64'(req_ready), 64'd0);
    step();
    check("bp.wait_valid", 64'(rsp_valid), 64'd0);
    step();
    check("bp.valid", 64'(rsp_valid), 64'd1);
    check("bp.rdata", 64'(rsp_rdata), 64'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp.hold%0d.valid", i), 64'(rsp_valid), 64'd1);
      check($sformatf("bp.hold%0d.rdata", i), 64'(rsp_rdata), 64'hCAFEF00D);
      check($sformatf("bp.hold%0d.ready", i), 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp.hs.valid", 64'(rsp_valid), 64'd0);
    check("bp.hs.ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    check("bp.queued_accept", 64'(req_ready), 64'd0);
    step();
    step();
    check("bp.queued_valid", 64'(rsp_valid), 64'd1);
    check("bp.queued_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    step();
    check("bp.queued_done", 64'(rsp_valid), 64'd0);

    // Address checking (or wrapping when the check is compiled out)
    transact("wr00", 1'b1, 32'h0, 32'h01020304, 4'hF, 32'h0, 1'b0);
`ifdef MIPS_DMEM_ERR_CHECK_EN
    transact("err.wr13", 1'b1, 32'h13, 32'h5555AAAA, 4'hF, 32'h0, 1'b1);
    transact("err.rd400", 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1);
    transact("err.rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
`else
    transact("wrap.wr13", 1'b1, 32'h13, 32'h5555AAAA, 4'hF, 32'h0, 1'b0);
    transact("wrap.rd400", 1'b0, 32'h400, 32'h0, 4'h0, 32'h01020304, 1'b0);
    transact("wrap.rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'h5555AAAA, 1'b0);
`endif

    // Reset during WAIT: write already performed, response abandoned
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h77778888;
    req_be    = 4'hF;
    check("mid.ready_idle", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid.rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid.req_ready", 64'(req_ready), 64'd0);
    step();
    step();
    check("mid.held_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b1;
    #1;
    check("mid.ready_before_edge", 64'(req_ready), 64'd0);
    step();
    check("mid.ready_first_edge", 64'(req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("mid.no_rsp%0d", i), 64'(rsp_valid), 64'd0);
    end
    transact("mid.rd40", 1'b0, 32'h40, 32'h0, 4'h0, 32'h77778888, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mips_dmem_resp
